rca_byte_sequencer: RTL and testbench

Multi-cycle wide adder front-end that drives an external 8-bit ripple-carry adder stage (`RCA_8_bit`) one byte per clock. It accepts wide operands over a valid/ready handshake and presents the low byte first. It registers the adder's carry-out between bytes and assembles the per-byte sums into a full-width result, returned over a second valid/ready handshake. The block sits between the operand source and the 8-bit adder, and both feeds and consumes that adder.

---
 rtl/rca_byte_sequencer.sv | 145 ++++++++++++++
 tb/tb_rca_byte_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rca_byte_sequencer.sv
// rca_byte_sequencer: multi-cycle wide adder front-end that feeds an external
// 8-bit ripple-carry adder one byte per clock, low byte first. It registers the
// inter-byte carry and assembles the per-byte sums into a full-width result.
// Optional feature: define RCA_SEQ_OVF_EN to add the registered signed-overflow
// output 'ovf'.
module rca_byte_sequencer #(
    parameter int unsigned NBYTES = 4,
    localparam int unsigned W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
`ifdef RCA_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_s,
    input  logic         add_cout
);

    localparam int unsigned IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NBYTES-1:0][7:0] a_q, a_d;
    logic [NBYTES-1:0][7:0] b_q, b_d;
    logic [NBYTES-1:0][7:0] sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
    logic                   ovf_q, ovf_d;
`endif

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state, byte-slice sequencing and adder drive.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a         = a_q[idx_q];
                add_b         = b_q[idx_q];
                add_cin       = carry_q;
                sum_d[idx_q]  = add_s;
                carry_d       = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Wrap idx to 0 explicitly so it never exceeds NBYTES-1
                    // when NBYTES is not a power of two.
                    idx_d   = '0;
                    cout_d  = add_cout;
                    state_d = S_DONE;
`ifdef RCA_SEQ_OVF_EN
                    // Final sum MSB is add_s[7] this cycle, not yet in sum_q.
                    ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                              (add_s[7] != a_q[NBYTES-1][7]);
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign c_out     = cout_q;
`ifdef RCA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_byte_sequencer.sv
// Directed testbench for rca_byte_sequencer (NBYTES=4) with a behavioural
// 8-bit adder standing in for RCA_8_bit.
module tb_rca_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
`ifdef RCA_SEQ_OVF_EN
    logic        ovf;
`endif
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_s;
    logic        add_cout;

    int nvec;
    int nerr;

    rca_byte_sequencer #(.NBYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
`ifdef RCA_SEQ_OVF_EN
        .ovf      (ovf),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Combinational 8-bit ripple-carry adder stand-in.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation; hold = cycles of out_ready=0 in DONE while junk
    // operands are offered on in_valid.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                         input logic [31:0] es, input logic ec, input logic eovf,
                         input int hold);
        logic [31:0] s_snap;
        logic        c_snap;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        c_in = tci;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("add_a_byte", {24'd0, add_a}, {24'd0, ta[8*k +: 8]});
            chk("add_b_byte", {24'd0, add_b}, {24'd0, tb_v[8*k +: 8]});
            chk("out_valid_run", {31'd0, out_valid}, 32'd0);
            chk("in_ready_run", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("out_valid_done", {31'd0, out_valid}, 32'd1);
        chk("sum", sum, es);
        chk("c_out", {31'd0, c_out}, {31'd0, ec});
`ifdef RCA_SEQ_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, eovf});
`else
        if (eovf === 1'bx) $display("unused overflow expectation");
`endif
        s_snap = sum;
        c_snap = c_out;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 32'hDEAD_BEEF;
            b = 32'h0101_0101;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum_stable", sum, s_snap);
            chk("bp_cout_stable", {31'd0, c_out}, {31'd0, c_snap});
            chk("bp_add_a_zero", {24'd0, add_a}, 32'd0);
        end
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("sum_held_idle", sum, es);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        #23;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_add_a", {24'd0, add_a}, 32'd0);
        chk("rst_add_b", {24'd0, add_b}, 32'd0);
        chk("rst_add_cin", {31'd0, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, latency checked inside do_op
        do_op(32'h0000_006D, 32'h0000_0066, 1'b0, 32'h0000_00D3, 1'b0, 1'b0, 0);
        // Full carry ripple
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
        // Carry-in with byte carry
        do_op(32'h0000_00F3, 32'h0000_000F, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 0);
        // Backpressure: 5 cycles in DONE, result leaves c_out=1
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5);

        // Reset mid-RUN after two byte edges
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_run_add_a", {24'd0, add_a}, 32'h0000_00AA);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_sum", sum, 32'd0);
        chk("abort_add_a", {24'd0, add_a}, 32'd0);
        chk("abort_c_out", {31'd0, c_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);

`ifdef RCA_SEQ_OVF_EN
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
